// File: rtl/bp_be_retire_serializer.sv
// bp_be_retire_serializer
// Collects up to two retiring instructions per cycle from the dual-issue
// commit point (slot0 older, slot1 younger), keeps them in program order in
// a small circular buffer and presents one retire packet per cycle to the
// single-ported CSR retire interface through a valid/yumi handshake.
//
// Optional feature macro: BP_BE_RETIRE_SERIALIZER_BYPASS_EN
//   When defined, an empty buffer forwards slot0 combinationally to the head
//   outputs (zero-cycle latency). When undefined, every entry is visible one
//   cycle after it is written and no input reaches an output combinationally.
module bp_be_retire_serializer #(
  parameter int vaddr_width_p   = 39,
  parameter int instr_width_p   = 32,
  parameter int data_width_p    = 64,
  parameter int exc_width_p     = 16,
  parameter int special_width_p = 8,
  parameter int els_p           = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,

  input  logic                       retire0_v_i,
  input  logic [vaddr_width_p-1:0]   retire0_pc_i,
  input  logic [vaddr_width_p-1:0]   retire0_vaddr_i,
  input  logic [instr_width_p-1:0]   retire0_instr_i,
  input  logic [data_width_p-1:0]    retire0_data_i,
  input  logic [exc_width_p-1:0]     retire0_exception_i,
  input  logic [special_width_p-1:0] retire0_special_i,

  input  logic                       retire1_v_i,
  input  logic [vaddr_width_p-1:0]   retire1_pc_i,
  input  logic [vaddr_width_p-1:0]   retire1_vaddr_i,
  input  logic [instr_width_p-1:0]   retire1_instr_i,
  input  logic [data_width_p-1:0]    retire1_data_i,
  input  logic [exc_width_p-1:0]     retire1_exception_i,
  input  logic [special_width_p-1:0] retire1_special_i,

  output logic                       ready_o,
  output logic                       retire_v_o,
  output logic [vaddr_width_p-1:0]   retire_pc_o,
  output logic [vaddr_width_p-1:0]   retire_vaddr_o,
  output logic [instr_width_p-1:0]   retire_instr_o,
  output logic [data_width_p-1:0]    retire_data_o,
  output logic [exc_width_p-1:0]     retire_exception_o,
  output logic [special_width_p-1:0] retire_special_o,
  output logic                       retire_instret_o,
  input  logic                       retire_yumi_i,
  output logic [$clog2(els_p):0]     count_o,
  output logic                       overflow_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = ptr_w + 1;
  localparam int ent_w = 2*vaddr_width_p + instr_width_p + data_width_p
                       + exc_width_p + special_width_p;
  // Highest occupancy at which two more entries still fit.
  localparam logic [cnt_w-1:0] ready_lim_lp = cnt_w'(els_p - 2);

  logic [ent_w-1:0] mem_q [els_p];
  logic [ent_w-1:0] mem_d [els_p];
  logic [ptr_w-1:0] rptr_q, rptr_d;
  logic [ptr_w-1:0] wptr_q, wptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [ent_w-1:0] slot0_ent, slot1_ent, head_ent;
  logic             ready_s;
  logic             byp_s;
  logic             wr0_s, wr1_s, deq_s;
  logic [ptr_w-1:0] wr1_addr_s;
  logic [cnt_w-1:0] enq_n_s;

  assign slot0_ent = {retire0_pc_i, retire0_vaddr_i, retire0_instr_i,
                      retire0_data_i, retire0_exception_i, retire0_special_i};
  assign slot1_ent = {retire1_pc_i, retire1_vaddr_i, retire1_instr_i,
                      retire1_data_i, retire1_exception_i, retire1_special_i};

  // Depends only on registered occupancy, never on this cycle's yumi.
  assign ready_s = (count_q <= ready_lim_lp);

`ifdef BP_BE_RETIRE_SERIALIZER_BYPASS_EN
  assign byp_s    = (count_q == '0) & retire0_v_i;
  assign head_ent = byp_s ? slot0_ent : mem_q[rptr_q];
`else
  assign byp_s    = 1'b0;
  assign head_ent = mem_q[rptr_q];
`endif

  // Decide which slots are written this cycle and where slot1 lands.
  always_comb begin
    wr0_s      = 1'b0;
    wr1_s      = 1'b0;
    deq_s      = 1'b0;
    wr1_addr_s = wptr_q;
    enq_n_s    = '0;
    if (ready_s && !flush_i) begin
      // A bypassed-and-consumed slot0 never needs a buffer entry.
      wr0_s = retire0_v_i & ~(byp_s & retire_yumi_i);
      // An excepting older instruction kills the younger one.
      wr1_s = retire1_v_i & ~(retire0_v_i & (|retire0_exception_i));
    end else begin
      wr0_s = 1'b0;
      wr1_s = 1'b0;
    end
    if (wr0_s) begin
      wr1_addr_s = wptr_q + ptr_w'(1);
    end else begin
      wr1_addr_s = wptr_q;
    end
    enq_n_s = cnt_w'(wr0_s) + cnt_w'(wr1_s);
    // Only a real buffered head can be dequeued; yumi on empty is ignored.
    deq_s   = (count_q != '0) & retire_yumi_i;
  end

  // Next-state for storage, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (~ready_s & (retire0_v_i | retire1_v_i));
    if (flush_i) begin
      // The head may still retire this cycle, but everything else is dropped.
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (wr0_s && (ptr_w'(i) == wptr_q)) begin
          mem_d[i] = slot0_ent;
        end else if (wr1_s && (ptr_w'(i) == wr1_addr_s)) begin
          mem_d[i] = slot1_ent;
        end else begin
          mem_d[i] = mem_q[i];
        end
      end
      rptr_d  = rptr_q + ptr_w'(deq_s);
      wptr_d  = wptr_q + enq_n_s[ptr_w-1:0];
      count_d = count_q + enq_n_s - cnt_w'(deq_s);
    end
  end

  // State registers; reset empties the buffer immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready_o    = ready_s;
  assign retire_v_o = (count_q != '0) | byp_s;
  assign {retire_pc_o, retire_vaddr_o, retire_instr_o,
          retire_data_o, retire_exception_o, retire_special_o} = head_ent;
  assign retire_instret_o = retire_v_o & ~(|retire_exception_o);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bp_be_retire_serializer.sv
// Directed testbench for bp_be_retire_serializer (default build, els_p=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bp_be_retire_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        v0, v1, yumi;
  logic [38:0] pc0, pc1;
  logic [15:0] exc0;

  logic        ready, rv, instret, ovf;
  logic [38:0] rpc, rvaddr;
  logic [31:0] rinstr;
  logic [63:0] rdata;
  logic [15:0] rexc;
  logic [7:0]  rspec;
  logic [2:0]  cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_be_retire_serializer dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .retire0_v_i(v0), .retire0_pc_i(pc0), .retire0_vaddr_i(pc0 + 39'h100),
    .retire0_instr_i(32'h0000_0013), .retire0_data_i({25'h0, pc0}),
    .retire0_exception_i(exc0), .retire0_special_i(8'h00),
    .retire1_v_i(v1), .retire1_pc_i(pc1), .retire1_vaddr_i(pc1 + 39'h100),
    .retire1_instr_i(32'h0000_0033), .retire1_data_i({25'h0, pc1}),
    .retire1_exception_i(16'h0000), .retire1_special_i(8'h00),
    .ready_o(ready), .retire_v_o(rv), .retire_pc_o(rpc),
    .retire_vaddr_o(rvaddr), .retire_instr_o(rinstr), .retire_data_o(rdata),
    .retire_exception_o(rexc), .retire_special_o(rspec),
    .retire_instret_o(instret), .retire_yumi_i(yumi),
    .count_o(cnt), .overflow_o(ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a0, input logic [38:0] p0, input logic [15:0] e0,
                       input logic a1, input logic [38:0] p1);
    v0 = a0; pc0 = p0; exc0 = e0; v1 = a1; pc1 = p1;
  endtask

  task automatic idle();
    drive(1'b0, 39'h0, 16'h0, 1'b0, 39'h0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; yumi = 1'b0;
    idle();
    #12;
    check_eq("rst_count", {61'h0, cnt}, 64'd0);
    check_eq("rst_v", {63'h0, rv}, 64'd0);
    check_eq("rst_ovf", {63'h0, ovf}, 64'd0);
    check_eq("rst_pc", {25'h0, rpc}, 64'd0);
    check_eq("rst_ready", {63'h0, ready}, 64'd1);
    reset_n = 1'b1;
    step();

    // 1: pair with yumi held high; count 0,2,1,0
    yumi = 1'b1;
    drive(1'b1, 39'h1000, 16'h0, 1'b1, 39'h1004);
    check_eq("t1_cnt0", {61'h0, cnt}, 64'd0);
    check_eq("t1_v0", {63'h0, rv}, 64'd0);
    step(); idle();
    check_eq("t1_cnt2", {61'h0, cnt}, 64'd2);
    check_eq("t1_pc_a", {25'h0, rpc}, 64'h1000);
    check_eq("t1_vaddr_a", {25'h0, rvaddr}, 64'h1100);
    step();
    check_eq("t1_cnt1", {61'h0, cnt}, 64'd1);
    check_eq("t1_pc_b", {25'h0, rpc}, 64'h1004);
    check_eq("t1_instr_b", {32'h0, rinstr}, 64'h33);
    step();
    check_eq("t1_cnt_end", {61'h0, cnt}, 64'd0);
    check_eq("t1_v_end", {63'h0, rv}, 64'd0);

    // 2: excepting slot0 kills slot1
    yumi = 1'b0;
    drive(1'b1, 39'h2000, 16'h0004, 1'b1, 39'h2004);
    step(); idle();
    check_eq("t2_cnt", {61'h0, cnt}, 64'd1);
    check_eq("t2_instret", {63'h0, instret}, 64'd0);
    check_eq("t2_exc", {48'h0, rexc}, 64'h0004);
    check_eq("t2_pc", {25'h0, rpc}, 64'h2000);
    yumi = 1'b1;
    step();
    check_eq("t2_cnt_end", {61'h0, cnt}, 64'd0);
    check_eq("t2_ovf", {63'h0, ovf}, 64'd0);
    yumi = 1'b0;

    // 3: fill, overflow, drain in order
    drive(1'b1, 39'h3000, 16'h0, 1'b1, 39'h3004);
    step();
    check_eq("t3_cnt2", {61'h0, cnt}, 64'd2);
    check_eq("t3_ready2", {63'h0, ready}, 64'd1);
    drive(1'b1, 39'h3008, 16'h0, 1'b1, 39'h300c);
    step();
    check_eq("t3_cnt4", {61'h0, cnt}, 64'd4);
    check_eq("t3_ready4", {63'h0, ready}, 64'd0);
    drive(1'b1, 39'h3010, 16'h0, 1'b1, 39'h3014);
    step(); idle();
    check_eq("t3_ovf", {63'h0, ovf}, 64'd1);
    check_eq("t3_cnt_hold", {61'h0, cnt}, 64'd4);
    check_eq("t3_instret", {63'h0, instret}, 64'd1);
    yumi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_drain%0d", i), {25'h0, rpc}, 64'h3000 + 64'(4*i));
      step();
    end
    check_eq("t3_cnt_end", {61'h0, cnt}, 64'd0);
    yumi = 1'b0;

    // 4: fill to 3, flush with yumi and a new pair
    drive(1'b1, 39'h4000, 16'h0, 1'b1, 39'h4004);
    step();
    drive(1'b1, 39'h4008, 16'h0, 1'b0, 39'h0);
    step(); idle();
    check_eq("t4_cnt3", {61'h0, cnt}, 64'd3);
    flush = 1'b1; yumi = 1'b1;
    drive(1'b1, 39'h4100, 16'h0, 1'b1, 39'h4104);
    check_eq("t4_head_v", {63'h0, rv}, 64'd1);
    check_eq("t4_head_pc", {25'h0, rpc}, 64'h4000);
    step(); idle(); flush = 1'b0; yumi = 1'b0;
    check_eq("t4_cnt0", {61'h0, cnt}, 64'd0);
    check_eq("t4_v0", {63'h0, rv}, 64'd0);
    step();
    check_eq("t4_cnt_after", {61'h0, cnt}, 64'd0);
    check_eq("t4_ready", {63'h0, ready}, 64'd1);

    // 5: single slot1 stream with yumi, pointers wrap
    yumi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 39'h0, 16'h0, 1'b1, 39'h5000 + 39'(4*i));
      step();
      check_eq($sformatf("t5_cnt%0d", i), {61'h0, cnt}, 64'd1);
      check_eq($sformatf("t5_pc%0d", i), {25'h0, rpc}, 64'h5000 + 64'(4*i));
    end
    idle();
    step();
    check_eq("t5_cnt_end", {61'h0, cnt}, 64'd0);
    yumi = 1'b0;

    // 6: asynchronous reset mid-stream
    drive(1'b1, 39'h6000, 16'h0, 1'b1, 39'h6004);
    step();
    drive(1'b1, 39'h6008, 16'h0, 1'b0, 39'h0);
    step(); idle();
    check_eq("t6_cnt3", {61'h0, cnt}, 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_v", {63'h0, rv}, 64'd0);
    check_eq("t6_rst_cnt", {61'h0, cnt}, 64'd0);
    check_eq("t6_rst_ovf", {63'h0, ovf}, 64'd0);
    check_eq("t6_rst_pc", {25'h0, rpc}, 64'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("t6_cnt_after", {61'h0, cnt}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
